// File: rtl/h2c_cmd_decoder_pkg.sv
// Shared definitions for the h2c command decoder: opcodes, header layout, FSM states.
package h2c_cmd_decoder_pkg;

    localparam int unsigned H2C_DATA_W  = 256;
    localparam int unsigned H2C_INSTR_W = 64;
    localparam int unsigned H2C_IMEM_AW = 10;

    localparam logic [7:0] H2C_OP_LOAD       = 8'h01;
    localparam logic [7:0] H2C_OP_START      = 8'h02;
    localparam logic [7:0] H2C_OP_USER_RST   = 8'h03;
    localparam logic [7:0] H2C_OP_PER_CFG    = 8'h04;
    localparam logic [7:0] H2C_OP_RBE_SWITCH = 8'h05;
    localparam logic [7:0] H2C_OP_DLL_TOGGLE = 8'h06;
    localparam logic [7:0] H2C_OP_CLR_ERR    = 8'h07;

    // Header occupies tdata[63:0]: op [7:0], len [31:16], arg [63:32]
    typedef struct packed {
        logic [31:0] arg;
        logic [15:0] len;
        logic [7:0]  rsvd;
        logic [7:0]  op;
    } h2c_hdr_t;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } h2c_state_e;

    function automatic int unsigned h2c_lanes(input int unsigned data_w, input int unsigned instr_w);
        return data_w / instr_w;
    endfunction

endpackage

// File: rtl/h2c_cmd_decoder_if.sv
// h2c stream plus instruction-memory write port seen by the command decoder.
interface h2c_cmd_decoder_if #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned INSTR_W = 64,
    parameter int unsigned IMEM_AW = 10
) ();
    logic [DATA_W-1:0]   h2c_tdata;
    logic                h2c_tvalid;
    logic                h2c_tlast;
    logic [DATA_W/8-1:0] h2c_tkeep;
    logic                h2c_tready;
    logic                imem_we;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;
    logic                imem_ready;

    modport master (
        output h2c_tdata, h2c_tvalid, h2c_tlast, h2c_tkeep, imem_ready,
        input  h2c_tready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  h2c_tdata, h2c_tvalid, h2c_tlast, h2c_tkeep, imem_ready,
        output h2c_tready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/h2c_cmd_decoder_lane_unpacker.sv
// Splits one DATA_W payload beat into LANES serial instruction writes, lane 0 first,
// holding the write strobe until imem_ready.
module h2c_lane_unpacker
    import h2c_cmd_decoder_pkg::*;
#(
    parameter int unsigned DATA_W  = H2C_DATA_W,
    parameter int unsigned INSTR_W = H2C_INSTR_W,
    parameter int unsigned IMEM_AW = H2C_IMEM_AW
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               load,
    input  logic [DATA_W-1:0]  beat,
    input  logic               addr_set,
    input  logic [IMEM_AW-1:0] addr_base,
    input  logic               imem_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               drain_nx_c
);
    localparam int unsigned LANES = h2c_lanes(DATA_W, INSTR_W);
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [DATA_W-1:0]  sreg_q, sreg_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [IMEM_AW-1:0] addr_q, addr_n;
    logic               we_q, we_n;
    logic               wr_c;

    assign wr_c       = we_q & imem_ready;
    // Empty next cycle unless a new beat is loaded
    assign drain_nx_c = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && imem_ready);

    always_comb begin
        sreg_n = sreg_q;
        cnt_n  = cnt_q;
        addr_n = addr_q;
        if (addr_set) begin
            addr_n = addr_base;
        end
        if (load) begin
            sreg_n = beat;
            cnt_n  = CNT_W'(LANES);
        end else if (wr_c) begin
            sreg_n = sreg_q >> INSTR_W;
            cnt_n  = cnt_q - CNT_W'(1);
            addr_n = addr_q + IMEM_AW'(1);
        end
        we_n = (cnt_n != '0);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
        end else begin
            sreg_q <= sreg_n;
            cnt_q  <= cnt_n;
            addr_q <= addr_n;
            we_q   <= we_n;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = sreg_q[INSTR_W-1:0];

endmodule

// File: rtl/h2c_cmd_decoder.sv
// Host-to-card command receiver: decodes framed h2c packets into imem writes and
// control pulses for the pipeline and readback engine.
module h2c_cmd_decoder
    import h2c_cmd_decoder_pkg::*;
#(
    parameter int unsigned DATA_W  = H2C_DATA_W,
    parameter int unsigned INSTR_W = H2C_INSTR_W,
    parameter int unsigned IMEM_AW = H2C_IMEM_AW
) (
    input  logic               clk,
    input  logic               rst_l,
    h2c_cmd_decoder_if.slave   bus,
    input  logic               softmc_busy,
    output logic               start,
    output logic [IMEM_AW-1:0] start_addr,
    output logic               user_rst,
    output logic               rbe_switch,
    output logic               dll_toggle,
    output logic [2:0]         per_en,
    output logic               err
);
    h2c_state_e         state_q, state_n;
    logic [15:0]        rem_q, rem_n;
    logic               load_end_q, load_end_n, end_drain_q, end_drain_n;
    logic               alive_q, tready_q, tready_n, err_q, err_n;
    logic               start_q, start_n, urst_q, urst_n, rbe_q, rbe_n, dll_q, dll_n;
    logic [IMEM_AW-1:0] start_addr_q, start_addr_n;
    logic [2:0]         per_en_q, per_en_n;
    logic               err_set, err_clr, unp_load_c, addr_set_c, drain_nx_c;
    logic               acc_c, framed_c, unused_c;
    h2c_hdr_t           hdr;

    assign hdr      = h2c_hdr_t'(bus.h2c_tdata[63:0]);
    assign acc_c    = bus.h2c_tvalid & tready_q;
    assign framed_c = (hdr.len == 16'd0) && bus.h2c_tlast;
    assign unused_c = ^{hdr.rsvd, hdr.arg[31:IMEM_AW], bus.h2c_tkeep};

    always_comb begin
        state_n      = state_q;
        rem_n        = rem_q;
        load_end_n   = load_end_q;
        end_drain_n  = end_drain_q;
        start_addr_n = start_addr_q;
        per_en_n     = per_en_q;
        start_n      = 1'b0;
        urst_n       = 1'b0;
        rbe_n        = 1'b0;
        dll_n        = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        unp_load_c   = 1'b0;
        addr_set_c   = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (acc_c) begin
                    case (hdr.op)
                        H2C_OP_LOAD: begin
                            addr_set_c = 1'b1;
                            if ((hdr.len != 16'd0) && !bus.h2c_tlast) begin
                                state_n = ST_LOAD;
                                rem_n   = hdr.len;
                            end else if (!framed_c) begin
                                err_set = 1'b1;
                                state_n = bus.h2c_tlast ? ST_HDR : ST_DRAIN;
                            end
                        end
                        H2C_OP_START: begin
                            if (softmc_busy) begin
                                err_set = 1'b1;
                            end else begin
                                start_n      = 1'b1;
                                start_addr_n = hdr.arg[IMEM_AW-1:0];
                            end
                        end
                        H2C_OP_USER_RST:   urst_n   = 1'b1;
                        H2C_OP_PER_CFG:    per_en_n = hdr.arg[2:0];
                        H2C_OP_RBE_SWITCH: rbe_n    = 1'b1;
                        H2C_OP_DLL_TOGGLE: dll_n    = 1'b1;
                        H2C_OP_CLR_ERR:    err_clr  = 1'b1;
                        default:           err_set  = 1'b1;
                    endcase
                    // Single-beat commands must be exactly one beat long; op still executes
                    if ((hdr.op != H2C_OP_LOAD) && !framed_c) begin
                        err_set = 1'b1;
                        state_n = bus.h2c_tlast ? ST_HDR : ST_DRAIN;
                    end
                end
            end
            ST_LOAD: begin
                if (load_end_q) begin
                    if (drain_nx_c) begin
                        state_n    = end_drain_q ? ST_DRAIN : ST_HDR;
                        load_end_n = 1'b0;
                    end
                end else if (acc_c) begin
                    unp_load_c = 1'b1;
                    rem_n      = rem_q - 16'd1;
                    if (bus.h2c_tlast) begin
                        load_end_n  = 1'b1;
                        end_drain_n = 1'b0;
                        err_set     = (rem_q != 16'd1);
                    end else if (rem_q == 16'd1) begin
                        load_end_n  = 1'b1;
                        end_drain_n = 1'b1;
                        err_set     = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (acc_c && bus.h2c_tlast) begin
                    state_n = ST_HDR;
                end
            end
            default: state_n = ST_HDR;
        endcase
        err_n    = err_set | (err_q & ~err_clr);
        tready_n = alive_q & ((state_n != ST_LOAD) | (drain_nx_c & ~unp_load_c & ~load_end_n));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_HDR;
            rem_q        <= '0;
            load_end_q   <= 1'b0;
            end_drain_q  <= 1'b0;
            alive_q      <= 1'b0;
            tready_q     <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            urst_q       <= 1'b0;
            rbe_q        <= 1'b0;
            dll_q        <= 1'b0;
            start_addr_q <= '0;
            per_en_q     <= '0;
        end else begin
            state_q      <= state_n;
            rem_q        <= rem_n;
            load_end_q   <= load_end_n;
            end_drain_q  <= end_drain_n;
            alive_q      <= 1'b1;
            tready_q     <= tready_n;
            err_q        <= err_n;
            start_q      <= start_n;
            urst_q       <= urst_n;
            rbe_q        <= rbe_n;
            dll_q        <= dll_n;
            start_addr_q <= start_addr_n;
            per_en_q     <= per_en_n;
        end
    end

    h2c_lane_unpacker #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W),
        .IMEM_AW (IMEM_AW)
    ) u_unpacker (
        .clk        (clk),
        .rst_l      (rst_l),
        .load       (unp_load_c),
        .beat       (bus.h2c_tdata),
        .addr_set   (addr_set_c),
        .addr_base  (hdr.arg[IMEM_AW-1:0]),
        .imem_ready (bus.imem_ready),
        .imem_we    (bus.imem_we),
        .imem_addr  (bus.imem_addr),
        .imem_wdata (bus.imem_wdata),
        .drain_nx_c (drain_nx_c)
    );

    assign bus.h2c_tready = tready_q;
    assign start          = start_q;
    assign start_addr     = start_addr_q;
    assign user_rst       = urst_q;
    assign rbe_switch     = rbe_q;
    assign dll_toggle     = dll_q;
    assign per_en         = per_en_q;
    assign err            = err_q;

endmodule
